// File: rtl/uart_param_core.sv
// uart_param_core: parametrised UART with programmable baud tick, 16x oversampled RX/TX FSMs,
// FWFT RX/TX FIFOs and sticky line-error flags.
// Optional feature macro: UART_PARITY_EN adds a parity bit after the data bits in both directions.

// FWFT FIFO: head visible on r_data, full/empty from an extra pointer MSB.
module uart_param_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full
);
  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          wr_ok;
  logic          rd_ok;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign wr_ok  = wr && (!full || rd);
  assign rd_ok  = rd && !empty;
  assign r_data = mem[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= w_data;
  end
endmodule

module uart_param_core #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  input  logic              rd_uart,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic              parity_odd,
  input  logic              err_clr,
  output logic              tx,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              tx_empty,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);
  localparam int unsigned S_W = 6;
  localparam int unsigned N_W = 4;
  localparam logic [S_W-1:0]    S_ONE      = S_W'(1);
  localparam logic [S_W-1:0]    S_MID      = S_W'(7);
  localparam logic [S_W-1:0]    S_BIT_END  = S_W'(15);
  localparam logic [S_W-1:0]    S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_ONE      = N_W'(1);
  localparam logic [N_W-1:0]    N_LAST     = N_W'(DBIT - 1);
  localparam logic [DVSR_W-1:0] DVSR_ONE   = DVSR_W'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- baud tick
  logic [DVSR_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q >= dvsr);

  // Free-running tick counter; a count left above a newly lowered dvsr wraps at once.
  always_ff @(posedge clk) begin
    if (!reset_n)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + DVSR_ONE;
  end

  // ---------------------------------------------------------------- FIFOs
  logic            rx_push_c;
  logic [DBIT-1:0] rx_head;
  logic            tx_pop_c;
  logic [DBIT-1:0] tx_head;

  rx_state_t       rx_state_q, rx_state_d;
  logic [S_W-1:0]  rx_s_q, rx_s_d;
  logic [N_W-1:0]  rx_n_q, rx_n_d;
  logic [DBIT-1:0] rx_b_q, rx_b_d;
  logic            frame_set_c;
  logic            overrun_set_c;

  uart_param_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .rd      (rd_uart),
    .wr      (rx_push_c),
    .w_data  (rx_b_q),
    .r_data  (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  uart_param_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .rd      (tx_pop_c),
    .wr      (wr_uart),
    .w_data  (w_data),
    .r_data  (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  // Head is forced to zero while empty so the port has a defined value out of reset.
  assign r_data = rx_empty ? '0 : rx_head;

  // ---------------------------------------------------------------- RX FSM
`ifdef UART_PARITY_EN
  logic parity_set_c;
`endif

  // RX state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
    end
  end

  // RX next state: mid-bit sampling, frame validation and FIFO push.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_s_d        = rx_s_q;
    rx_n_d        = rx_n_q;
    rx_b_d        = rx_b_q;
    rx_push_c     = 1'b0;
    frame_set_c   = 1'b0;
    overrun_set_c = 1'b0;
`ifdef UART_PARITY_EN
    parity_set_c  = 1'b0;
`endif
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx) begin
          rx_state_d = RX_START;
          rx_s_d     = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_s_q == S_MID) begin
            rx_s_d     = '0;
            rx_n_d     = '0;
            rx_state_d = rx ? RX_IDLE : RX_DATA;
          end else begin
            rx_s_d = rx_s_q + S_ONE;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_s_q == S_BIT_END) begin
            rx_s_d = '0;
            rx_b_d = {rx, rx_b_q[DBIT-1:1]};
            if (rx_n_q == N_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end else begin
              rx_n_d = rx_n_q + N_ONE;
            end
          end else begin
            rx_s_d = rx_s_q + S_ONE;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (rx_s_q == S_BIT_END) begin
            rx_s_d       = '0;
            rx_state_d   = RX_STOP;
            parity_set_c = rx ^ (^rx_b_q) ^ parity_odd;
          end else begin
            rx_s_d = rx_s_q + S_ONE;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          if (rx_s_q == S_STOP_END) begin
            rx_state_d = RX_IDLE;
            if (!rx)         frame_set_c   = 1'b1;
            else if (rx_full) overrun_set_c = 1'b1;
            else             rx_push_c     = 1'b1;
          end else begin
            rx_s_d = rx_s_q + S_ONE;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t       tx_state_q, tx_state_d;
  logic [S_W-1:0]  tx_s_q, tx_s_d;
  logic [N_W-1:0]  tx_n_q, tx_n_d;
  logic [DBIT-1:0] tx_b_q, tx_b_d;
  logic            tx_d;
`ifdef UART_PARITY_EN
  logic            tx_par_q, tx_par_d;
`endif

  // TX state, datapath and registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx         <= tx_d;
      tx_busy    <= (tx_state_d != TX_IDLE);
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // TX next state: pop, shift out LSB first, chain straight into the next frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_d       = 1'b1;
    tx_pop_c   = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop_c   = 1'b1;
          tx_b_d     = tx_head;
          tx_s_d     = '0;
          tx_state_d = TX_START;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_head) ^ parity_odd;
`endif
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (tx_s_q == S_BIT_END) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_s_d = tx_s_q + S_ONE;
          end
        end
      end
      TX_DATA: begin
        tx_d = tx_b_q[0];
        if (tick) begin
          if (tx_s_q == S_BIT_END) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == N_LAST) begin
`ifdef UART_PARITY_EN
              tx_state_d = TX_PARITY;
`else
              tx_state_d = TX_STOP;
`endif
            end else begin
              tx_n_d = tx_n_q + N_ONE;
            end
          end else begin
            tx_s_d = tx_s_q + S_ONE;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_d = tx_par_q;
        if (tick) begin
          if (tx_s_q == S_BIT_END) begin
            tx_s_d     = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_s_d = tx_s_q + S_ONE;
          end
        end
      end
`endif
      TX_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (tx_s_q == S_STOP_END) begin
            tx_s_d = '0;
            if (!tx_empty) begin
              tx_pop_c   = 1'b1;
              tx_b_d     = tx_head;
              tx_state_d = TX_START;
`ifdef UART_PARITY_EN
              tx_par_d   = (^tx_head) ^ parity_odd;
`endif
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_s_d = tx_s_q + S_ONE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- sticky errors
  // Sticky flags; a new error in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_set_c   | (frame_err   & ~err_clr);
      overrun_err <= overrun_set_c | (overrun_err & ~err_clr);
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity flag.
  always_ff @(posedge clk) begin
    if (!reset_n) parity_err <= 1'b0;
    else          parity_err <= parity_set_c | (parity_err & ~err_clr);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core (DBIT=8, SB_TICK=16, FIFO_AW=4, dvsr=3 -> 64 clks/bit).
// Builds with or without UART_PARITY_EN.
module tb_uart_param_core;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] dvsr = 11'd3;
  logic        rx;
  logic        rd_uart = 1'b0;
  logic        wr_uart = 1'b0;
  logic [7:0]  w_data = 8'h00;
  logic        parity_odd = 1'b0;
  logic        err_clr = 1'b0;
  logic        tx;
  logic [7:0]  r_data;
  logic        rx_empty, rx_full, tx_empty, tx_full, tx_busy;
  logic        frame_err, parity_err, overrun_err;

  logic        loop_en = 1'b1;
  logic        rx_drv = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  logic        par_flip = 1'b0;
`else
  localparam int NBITS = 10;
`endif

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param_core #(.DBIT(8), .SB_TICK(16), .FIFO_AW(4), .DVSR_W(11)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dvsr        (dvsr),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .parity_odd  (parity_odd),
    .err_clr     (err_clr),
    .tx          (tx),
    .r_data      (r_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .tx_empty    (tx_empty),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (tx === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rx_data(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_empty === 1'b0) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1; cyc(1); rd_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
  endtask

  // Drive one frame on rx_drv; a 0 stop bit is held 48 clks so it is sampled low.
  task automatic send_rx_frame(input logic [7:0] d, input logic stop_val);
    rx_drv = 1'b0; cyc(64);
    for (int k = 0; k < 8; k++) begin rx_drv = d[k]; cyc(64); end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ parity_odd ^ par_flip; cyc(64);
`endif
    rx_drv = stop_val; cyc(stop_val ? 64 : 48);
    rx_drv = 1'b1; cyc(16);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cyc(5);
    n_checks++; if (tx !== 1'b1)          $display("FAIL reset_tx: got %0b want 1", tx); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0)     $display("FAIL reset_tx_busy: got %0b want 0", tx_busy); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1)    $display("FAIL reset_rx_empty: got %0b want 1", rx_empty); else n_pass++;
    n_checks++; if (tx_empty !== 1'b1)    $display("FAIL reset_tx_empty: got %0b want 1", tx_empty); else n_pass++;
    n_checks++; if (rx_full !== 1'b0)     $display("FAIL reset_rx_full: got %0b want 0", rx_full); else n_pass++;
    n_checks++; if (tx_full !== 1'b0)     $display("FAIL reset_tx_full: got %0b want 0", tx_full); else n_pass++;
    n_checks++; if (frame_err !== 1'b0)   $display("FAIL reset_frame_err: got %0b want 0", frame_err); else n_pass++;
    n_checks++; if (parity_err !== 1'b0)  $display("FAIL reset_parity_err: got %0b want 0", parity_err); else n_pass++;
    n_checks++; if (overrun_err !== 1'b0) $display("FAIL reset_overrun_err: got %0b want 0", overrun_err); else n_pass++;
    n_checks++; if (r_data !== 8'h00)     $display("FAIL reset_r_data: got %02h want 00", r_data); else n_pass++;
    reset_n = 1'b1; cyc(2);
  endtask

  // 0xA5 looped back: check every bit on the line, then the received byte.
  task automatic test_single();
    bit ok;
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = 8'hA5;
`ifdef UART_PARITY_EN
    bits[9] = 1'b0;
`endif
    loop_en = 1'b1;
    w_data = 8'hA5; wr_uart = 1'b1; cyc(1); wr_uart = 1'b0;
    wait_tx_low(200, ok);
    n_checks++; if (!ok) $display("FAIL single_start: tx never went low within 200 clks"); else n_pass++;
    for (int k = 0; k < NBITS; k++) begin
      cyc(k == 0 ? 32 : 64);
      n_checks++;
      if (tx !== bits[k]) $display("FAIL single_bit%0d: tx=%0b want %0b", k, tx, bits[k]); else n_pass++;
      if (k == 0) begin
        n_checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", tx_busy); else n_pass++;
      end
    end
    wait_rx_data(200, ok);
    n_checks++; if (!ok || r_data !== 8'hA5) $display("FAIL single_rx: r_data=%02h seen=%0b want A5", r_data, ok); else n_pass++;
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0 || parity_err !== 1'b0)
      $display("FAIL single_errs: frame=%0b overrun=%0b parity=%0b want 000", frame_err, overrun_err, parity_err); else n_pass++;
    pop_rx();
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL single_pop: rx_empty=%0b want 1", rx_empty); else n_pass++;
    cyc(80);
    n_checks++; if (tx_busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_idle: tx_busy=%0b tx=%0b want 0,1", tx_busy, tx); else n_pass++;
  endtask

  // TX held slow: one byte in flight, 16 fill the FIFO, the next write is dropped.
  task automatic test_tx_full();
    bit ok;
    logic [7:0] exp_q [17];
    exp_q[0] = 8'h5A;
    for (int i = 0; i < 16; i++) exp_q[i+1] = 8'h10 + 8'(i);
    loop_en = 1'b1;
    dvsr = 11'd2047;
    w_data = 8'h5A; wr_uart = 1'b1; cyc(1); wr_uart = 1'b0;
    cyc(3);
    n_checks++; if (tx_empty !== 1'b1 || tx_busy !== 1'b1) $display("FAIL full_prime: tx_empty=%0b tx_busy=%0b want 1,1", tx_empty, tx_busy); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      w_data = 8'h10 + 8'(i); wr_uart = 1'b1; cyc(1);
      if (i == 14) begin
        n_checks++; if (tx_full !== 1'b0) $display("FAIL full_after15: tx_full=%0b want 0", tx_full); else n_pass++;
      end
    end
    wr_uart = 1'b0;
    n_checks++; if (tx_full !== 1'b1) $display("FAIL full_after16: tx_full=%0b want 1", tx_full); else n_pass++;
    w_data = 8'hEE; wr_uart = 1'b1; cyc(1); wr_uart = 1'b0;
    n_checks++; if (tx_full !== 1'b1) $display("FAIL full_after17: tx_full=%0b want 1", tx_full); else n_pass++;
    dvsr = 11'd3;
    for (int i = 0; i < 17; i++) begin
      wait_rx_data(2000, ok);
      n_checks++;
      if (!ok || r_data !== exp_q[i]) $display("FAIL full_rx%0d: r_data=%02h seen=%0b want %02h", i, r_data, ok, exp_q[i]); else n_pass++;
      if (ok) pop_rx();
    end
    cyc(1000);
    n_checks++; if (rx_empty !== 1'b1 || tx_empty !== 1'b1) $display("FAIL full_dropped: rx_empty=%0b tx_empty=%0b want 1,1", rx_empty, tx_empty); else n_pass++;
  endtask

  task automatic test_frame_err();
    loop_en = 1'b0; rx_drv = 1'b1; cyc(20);
    send_rx_frame(8'h3C, 1'b0);
    cyc(100);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL frame_set: frame_err=%0b want 1", frame_err); else n_pass++;
    n_checks++; if (rx_empty !== 1'b1)  $display("FAIL frame_nostore: rx_empty=%0b want 1", rx_empty); else n_pass++;
    pulse_clr();
    n_checks++; if (frame_err !== 1'b0) $display("FAIL frame_clr: frame_err=%0b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_overrun();
    loop_en = 1'b0; rx_drv = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_rx_frame(8'h40 + 8'(i), 1'b1);
      if (i == 15) begin
        n_checks++; if (rx_full !== 1'b1 || overrun_err !== 1'b0) $display("FAIL ovr_full16: rx_full=%0b overrun=%0b want 1,0", rx_full, overrun_err); else n_pass++;
      end
    end
    n_checks++; if (overrun_err !== 1'b1) $display("FAIL ovr_set: overrun_err=%0b want 1", overrun_err); else n_pass++;
    n_checks++; if (frame_err !== 1'b0)   $display("FAIL ovr_frame: frame_err=%0b want 0", frame_err); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rx_empty !== 1'b0 || r_data !== 8'h40 + 8'(i)) $display("FAIL ovr_rd%0d: r_data=%02h rx_empty=%0b want %02h", i, r_data, rx_empty, 8'h40 + 8'(i)); else n_pass++;
      pop_rx();
    end
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL ovr_drained: rx_empty=%0b want 1", rx_empty); else n_pass++;
    pulse_clr();
    n_checks++; if (overrun_err !== 1'b0) $display("FAIL ovr_clr: overrun_err=%0b want 0", overrun_err); else n_pass++;
  endtask

  task automatic test_glitch();
    loop_en = 1'b0;
    rx_drv = 1'b0; cyc(16); rx_drv = 1'b1; cyc(700);
    n_checks++; if (rx_empty !== 1'b1) $display("FAIL glitch_nobyte: rx_empty=%0b want 1", rx_empty); else n_pass++;
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) $display("FAIL glitch_noerr: frame=%0b overrun=%0b want 0,0", frame_err, overrun_err); else n_pass++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    bit ok;
    loop_en = 1'b0; parity_odd = 1'b0; par_flip = 1'b1;
    send_rx_frame(8'h03, 1'b1);
    par_flip = 1'b0;
    wait_rx_data(100, ok);
    n_checks++; if (parity_err !== 1'b1) $display("FAIL parity_set: parity_err=%0b want 1", parity_err); else n_pass++;
    n_checks++; if (!ok || r_data !== 8'h03) $display("FAIL parity_data: r_data=%02h seen=%0b want 03", r_data, ok); else n_pass++;
    if (ok) pop_rx();
    pulse_clr();
    n_checks++; if (parity_err !== 1'b0) $display("FAIL parity_clr: parity_err=%0b want 0", parity_err); else n_pass++;
  endtask
`else
  task automatic test_parity();
    loop_en = 1'b0; parity_odd = 1'b1;
    send_rx_frame(8'h03, 1'b1);
    n_checks++; if (parity_err !== 1'b0) $display("FAIL parity_tied: parity_err=%0b want 0", parity_err); else n_pass++;
    n_checks++; if (rx_empty !== 1'b0 || r_data !== 8'h03) $display("FAIL parity_off_data: r_data=%02h rx_empty=%0b want 03", r_data, rx_empty); else n_pass++;
    pop_rx();
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_tx();
    bit ok;
    loop_en = 1'b1;
    w_data = 8'h81; wr_uart = 1'b1; cyc(1);
    w_data = 8'h7E; cyc(1); wr_uart = 1'b0;
    wait_tx_low(200, ok);
    cyc(100);
    n_checks++; if (!ok || tx_empty !== 1'b0 || tx_busy !== 1'b1) $display("FAIL rst_pre: seen=%0b tx_empty=%0b tx_busy=%0b want 1,0,1", ok, tx_empty, tx_busy); else n_pass++;
    reset_n = 1'b0; cyc(1);
    n_checks++; if (tx !== 1'b1)       $display("FAIL rst_tx: tx=%0b want 1", tx); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0)  $display("FAIL rst_busy: tx_busy=%0b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1) $display("FAIL rst_fifos: tx_empty=%0b rx_empty=%0b want 1,1", tx_empty, rx_empty); else n_pass++;
    reset_n = 1'b1; cyc(800);
    n_checks++; if (tx !== 1'b1 || rx_empty !== 1'b1 || frame_err !== 1'b0) $display("FAIL rst_after: tx=%0b rx_empty=%0b frame_err=%0b want 1,1,0", tx, rx_empty, frame_err); else n_pass++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tx_full();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_parity();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
